bus_peek_reader: RTL
====================

// Module: bus_peek_reader
// PURPOSE
//   Read-side initiator for the register-file peek port. Each debounced press
//   of the peek key reads one register over a req/ack handshake, shows its
//   10-bit value on HEX2..HEX0 and its index on HEX5, then advances to the next
//   register. It sits between the peek-key debouncer and the register file.
// PARAMETERS
//   DATA_W   10  width of the register/bus word (display logic is fixed to 10)
//   NREGS     8  number of registers stepped through, indices 0..NREGS-1
//   IDX_W     3  width of RdAddr, equal to clog2(NREGS)
//   TIMEOUT  15  max cycles in REQ with no RdAck before the read is aborted
// PORTS
//   CLK50MHz  in   1       system clock; all logic is on the rising edge
//   Reset     in   1       synchronous, active-high
//   PKdb      in   1       debounced peek key, level, 1 = pressed
//   Enable    in   1       1 = peeking allowed (e.g. processor halted/Done)
//   RdReq     out  1       read request to the register file
//   RdAddr    out  IDX_W   register index, held stable while RdReq=1
//   RdAck     in   1       register file: RdData valid this cycle
//   RdData    in   DATA_W  read data, sampled only when RdReq&RdAck
//   DHEX      out  7 x3    unpacked [2:0], active-low gfedcba; [0]=low nibble
//   THEX      out  7       active-low index digit (HEX5)
//   Valid     out  1       1 = displays hold a completed read
//   Err       out  1       1 = last read timed out
// BEHAVIOUR
//   - Reset: state IDLE, idx=0, RdReq=0, RdAddr=0, Valid=0, Err=0,
//     all DHEX/THEX=7'h7F (blank). pk_q (registered PKdb) cleared to 0.
//   - Press = PKdb&~pk_q, evaluated every cycle.
//   - FSM IDLE: on press&Enable -> REQ. Next cycle RdReq=1, RdAddr=idx, tmo=0.
//   - FSM REQ: RdReq stays 1 and RdAddr stays stable. On RdAck: capture RdData,
//     go to IDLE, and next cycle set RdReq=0, Valid=1, Err=0, display updated,
//     idx=(idx==NREGS-1)?0:idx+1. THEX shows the index just read, not the new idx.
//     If there is no ack, tmo increments. When tmo reaches TIMEOUT-1 with no ack,
//     go to IDLE with RdReq=0, Err=1, Valid=0, DHEX all = dash (7'h3F),
//     idx unchanged so the next press retries the same register.
//   - Latency: press seen at cycle n -> RdReq=1 at n+1. Ack at cycle m ->
//     RdReq=0 and new display at m+1. An ack in the first REQ cycle is legal.
//   - Digit mapping: DHEX[0]=hex(d[3:0]), DHEX[1]=hex(d[7:4]),
//     DHEX[2]=hex({2'b00,d[9:8]}). Full 0-F decode, active-low.
//   - Presses during REQ are dropped, not queued. A held key gives only one press.
//   - Enable=0: presses in IDLE are ignored. Enable falling during REQ does not
//     abort; the handshake completes normally.
//   - RdAck while RdReq=0 is ignored, including an ack arriving after a timeout.
//   - Reset mid-REQ: RdReq=0 on the next edge and all reset values apply.
//   - Wrap-around: after index NREGS-1 is read, the next read is index 0.
// TESTING
//   1 Reset, then no stimulus -> RdReq=0, Valid=0, Err=0, all HEX=7'h7F.
//   2 Press, ack after 2 cycles with RdData=10'h2A5 -> RdAddr=0 during REQ;
//     DHEX[2..0]=2,A,5 segs; THEX=0; Valid=1; next press reads RdAddr=1.
//   3 Eight presses, each acked -> RdAddr sequence 0..7 then 0; THEX follows.
//   4 Press, never ack -> RdReq high for exactly 15 cycles then 0; Err=1;
//     DHEX=dashes; next press reuses RdAddr=0; a late RdAck is ignored.
//   5 Hold PKdb high 100 cycles, and press again during REQ -> exactly one
//     request; Enable=0 press -> no request.
//   6 Assert Reset during REQ -> RdReq=0 next edge; all outputs at reset values.

Source files
------------

// File: rtl/bus_peek_reader.sv
`timescale 1ns/1ps
// Purpose: peek-key driven register reader; one debounced press reads one register
//          over req/ack, shows the value on HEX2..HEX0 and its index on HEX5.
// Latency: press at cycle n -> RdReq at n+1; ack at cycle m -> RdReq low and display at m+1.
// Backpressure: a slow register file holds RdReq up to TIMEOUT cycles before the read is abandoned.
//
// Ports:
//   CLK50MHz  system clock (rising edge)     Reset   synchronous, active-high
//   PKdb      debounced peek key (level)     Enable  1 = peeking allowed
//   RdReq     read request                   RdAddr  register index, stable while RdReq=1
//   RdAck     read data valid this cycle     RdData  read data, sampled on RdReq&RdAck
//   DHEX[2:0] active-low gfedcba data digits ([0] = low nibble)
//   THEX      active-low index digit         Valid   display holds a completed read
//   Err       last read timed out
module bus_peek_reader #(
  parameter int DATA_W  = 10,
  parameter int NREGS   = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK50MHz,
  input  logic              Reset,
  input  logic              PKdb,
  input  logic              Enable,
  output logic              RdReq,
  output logic [IDX_W-1:0]  RdAddr,
  input  logic              RdAck,
  input  logic [DATA_W-1:0] RdData,
  output logic [6:0]        DHEX [2:0],
  output logic [6:0]        THEX,
  output logic              Valid,
  output logic              Err
);

  localparam int TMO_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state, state_nxt;
  logic               pk_q;
  logic               press;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tmo;
  logic               start, done, expire;

  // Active-low gfedcba decode of one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_BLANK;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Rising edge of the debounced key; a held key yields a single press.
  assign press  = PKdb & ~pk_q;

  // RdReq follows the state directly, so it is registered and an ack seen
  // while RdReq=0 can never be mistaken for a response.
  assign RdReq  = (state == REQ);
  assign RdAddr = idx;

  always_ff @(posedge CLK50MHz) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        // Presses while a read is outstanding are simply not looked at.
        if (press && Enable) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Enable is deliberately ignored here: an issued read always completes
        // or times out. An ack in the final allowed cycle still wins.
        if (RdAck) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHz) begin
    if (Reset) begin
      pk_q  <= 1'b0;
      idx   <= '0;
      tmo   <= '0;
      Valid <= 1'b0;
      Err   <= 1'b0;
      THEX  <= SEG_BLANK;
      for (int i = 0; i < 3; i++) DHEX[i] <= SEG_BLANK;
    end else begin
      pk_q <= PKdb;

      if (start)
        tmo <= '0;
      else if (state == REQ && !done && !expire)
        tmo <= tmo + TMO_W'(1);

      if (done) begin
        DHEX[0] <= hex7(RdData[3:0]);
        DHEX[1] <= hex7(RdData[7:4]);
        DHEX[2] <= hex7({2'b00, RdData[9:8]});
        // Index digit shows the register just read, not the advanced pointer.
        THEX    <= hex7(4'(idx));
        Valid   <= 1'b1;
        Err     <= 1'b0;
        idx     <= (idx == IDX_W'(NREGS - 1)) ? '0 : idx + IDX_W'(1);
      end else if (expire) begin
        // idx is left alone so the next press retries the same register.
        for (int i = 0; i < 3; i++) DHEX[i] <= SEG_DASH;
        Valid <= 1'b0;
        Err   <= 1'b1;
      end
    end
  end

endmodule
